// File: rtl/scoreboard.sv
// Scoreboard: circular buffer tracking in-flight instructions from decode to in-order commit,
// capturing writebacks and providing operand forwarding and destination clobber information.
package scoreboard_pkg;
  localparam int NR_SB_ENTRIES = 4;
  localparam int NR_WB_PORTS   = 2;
  localparam int TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception;

  typedef struct packed {
    logic [63:0]              pc;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [3:0]               fu;
    logic [7:0]               op;
    logic [4:0]               rs1;
    logic [4:0]               rs2;
    logic [4:0]               rd;
    logic [63:0]              result;
    logic                     valid;
    exception                 ex;
  } scoreboard_entry;
endpackage

module scoreboard
  import scoreboard_pkg::scoreboard_entry, scoreboard_pkg::exception, scoreboard_pkg::TRANS_ID_BITS;
#(
  parameter int NR_ENTRIES  = scoreboard_pkg::NR_SB_ENTRIES,
  parameter int NR_WB_PORTS = scoreboard_pkg::NR_WB_PORTS
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      flush_i,
  output logic                                      full_o,
  input  scoreboard_entry                           decoded_instr_i,
  input  logic                                      decoded_instr_valid_i,
  output logic                                      decoded_instr_ack_o,
  output scoreboard_entry                           issue_instr_o,
  output logic                                      issue_instr_valid_o,
  input  logic                                      issue_ack_i,
  output logic [31:0]                               rd_clobber_o,
  input  logic [4:0]                                rs1_i,
  input  logic [4:0]                                rs2_i,
  output logic [63:0]                               rs1_o,
  output logic [63:0]                               rs2_o,
  output logic                                      rs1_valid_o,
  output logic                                      rs2_valid_o,
  input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] trans_id_i,
  input  logic [NR_WB_PORTS-1:0][63:0]              wdata_i,
  input  exception [NR_WB_PORTS-1:0]                ex_i,
  input  logic [NR_WB_PORTS-1:0]                    wb_valid_i,
  output scoreboard_entry                           commit_instr_o,
  output logic                                      commit_valid_o,
  input  logic                                      commit_ack_i
);

  localparam logic [TRANS_ID_BITS:0] FULL_COUNT = (TRANS_ID_BITS+1)'(NR_ENTRIES);

  scoreboard_entry          mem [NR_ENTRIES];
  logic [NR_ENTRIES-1:0]    occupied;
  logic [TRANS_ID_BITS-1:0] head;
  logic [TRANS_ID_BITS-1:0] tail;
  logic [TRANS_ID_BITS:0]   count;
  logic                     issue_fire;
  logic                     commit_fire;
  scoreboard_entry          alloc_entry;

  // Slot index 'offset' positions after 'base', wrapping modulo the buffer depth.
  function automatic logic [TRANS_ID_BITS-1:0] age_idx(input logic [TRANS_ID_BITS-1:0] base,
                                                       input int offset);
    return TRANS_ID_BITS'((int'(base) + offset) % NR_ENTRIES);
  endfunction

  // Handshakes: a transfer happens only in a cycle where the offering side's valid and the
  // taking side's ack are both high. Issue: issue_instr_valid_o / issue_ack_i, reported back to
  // decode as decoded_instr_ack_o. Commit: commit_valid_o / commit_ack_i. An ack without valid
  // has no effect; valid never depends on the ack of the same channel.
  assign full_o              = (count == FULL_COUNT);
  assign issue_instr_valid_o = decoded_instr_valid_i & ~full_o & ~flush_i;
  assign decoded_instr_ack_o = issue_instr_valid_o & issue_ack_i;
  assign issue_fire          = decoded_instr_ack_o;

  always_comb begin
    issue_instr_o          = decoded_instr_i;
    issue_instr_o.trans_id = tail;
  end

  // A newly allocated slot starts with no result and no exception.
  always_comb begin
    alloc_entry          = issue_instr_o;
    alloc_entry.valid    = 1'b0;
    alloc_entry.ex.valid = 1'b0;
  end

  assign commit_instr_o = mem[head];
  assign commit_valid_o = occupied[head] & mem[head].valid;
  assign commit_fire    = commit_valid_o & commit_ack_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      occupied <= '0;
    end else begin
      if (issue_fire) begin
        occupied[tail] <= 1'b1;
        tail           <= age_idx(tail, 1);
      end
      if (commit_fire) begin
        occupied[head] <= 1'b0;
        head           <= age_idx(head, 1);
      end
      if (issue_fire && !commit_fire) begin
        count <= count + 1'b1;
      end else if (commit_fire && !issue_fire) begin
        count <= count - 1'b1;
      end
    end
  end

  // Later ports override earlier ones when two writebacks target the same slot.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i) begin
      if (issue_fire) begin
        mem[tail] <= alloc_entry;
      end
      for (int p = 0; p < NR_WB_PORTS; p++) begin
        if (wb_valid_i[p] && occupied[trans_id_i[p]]) begin
          mem[trans_id_i[p]].result <= wdata_i[p];
          mem[trans_id_i[p]].valid  <= 1'b1;
          if (ex_i[p].valid) begin
            mem[trans_id_i[p]].ex <= ex_i[p];
          end
        end
      end
    end
  end

  always_comb begin
    rd_clobber_o = '0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      if (occupied[i] && !mem[i].valid) begin
        rd_clobber_o[mem[i].rd] = 1'b1;
      end
    end
    rd_clobber_o[0] = 1'b0;
  end

  // Walk oldest to youngest so the youngest matching producer is the last to assign.
  always_comb begin
    rs1_o       = '0;
    rs1_valid_o = 1'b0;
    rs2_o       = '0;
    rs2_valid_o = 1'b0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      if (occupied[age_idx(head, i)] && rs1_i != 5'd0 && mem[age_idx(head, i)].rd == rs1_i) begin
        rs1_valid_o = mem[age_idx(head, i)].valid;
        rs1_o       = mem[age_idx(head, i)].valid ? mem[age_idx(head, i)].result : '0;
      end
      if (occupied[age_idx(head, i)] && rs2_i != 5'd0 && mem[age_idx(head, i)].rd == rs2_i) begin
        rs2_valid_o = mem[age_idx(head, i)].valid;
        rs2_o       = mem[age_idx(head, i)].valid ? mem[age_idx(head, i)].result : '0;
      end
    end
  end

endmodule

// File: tb/tb_scoreboard.sv
// Bench for the scoreboard: directed scenarios plus a randomized run, all checked against a
// program-order queue model of the in-flight instructions.
module tb_scoreboard;
  import scoreboard_pkg::*;

  localparam int NE = 4;
  localparam int NP = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      flush;
  logic                      full;
  scoreboard_entry           dec_instr;
  logic                      dec_valid;
  logic                      dec_ack;
  scoreboard_entry           issue_instr;
  logic                      issue_valid;
  logic                      issue_ack;
  logic [31:0]               rd_clobber;
  logic [4:0]                rs1;
  logic [4:0]                rs2;
  logic [63:0]               rs1_data;
  logic [63:0]               rs2_data;
  logic                      rs1_valid;
  logic                      rs2_valid;
  logic [NP-1:0][1:0]        wb_id;
  logic [NP-1:0][63:0]       wdata;
  exception [NP-1:0]         ex;
  logic [NP-1:0]             wb_valid;
  scoreboard_entry           commit_instr;
  logic                      commit_valid;
  logic                      commit_ack;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  scoreboard #(.NR_ENTRIES(NE), .NR_WB_PORTS(NP)) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .flush_i               (flush),
    .full_o                (full),
    .decoded_instr_i       (dec_instr),
    .decoded_instr_valid_i (dec_valid),
    .decoded_instr_ack_o   (dec_ack),
    .issue_instr_o         (issue_instr),
    .issue_instr_valid_o   (issue_valid),
    .issue_ack_i           (issue_ack),
    .rd_clobber_o          (rd_clobber),
    .rs1_i                 (rs1),
    .rs2_i                 (rs2),
    .rs1_o                 (rs1_data),
    .rs2_o                 (rs2_data),
    .rs1_valid_o           (rs1_valid),
    .rs2_valid_o           (rs2_valid),
    .trans_id_i            (wb_id),
    .wdata_i               (wdata),
    .ex_i                  (ex),
    .wb_valid_i            (wb_valid),
    .commit_instr_o        (commit_instr),
    .commit_valid_o        (commit_valid),
    .commit_ack_i          (commit_ack)
  );

  // Reference model: in-flight instructions in program order.
  typedef struct {
    logic [1:0]  id;
    logic [4:0]  rd;
    logic [63:0] pc;
    logic [63:0] result;
    logic        done;
    exception    ex;
  } m_entry_t;

  m_entry_t    mq[$];
  int          m_tail = 0;
  logic [63:0] exp_q[$];

  task automatic model_update();
    m_entry_t e;
    bit fire_issue;
    bit fire_commit;
    if (rst || flush) begin
      mq.delete();
      m_tail = 0;
    end else begin
      fire_issue  = dec_valid && (mq.size() < NE) && issue_ack;
      fire_commit = commit_ack && (mq.size() > 0) && mq[0].done;
      for (int p = 0; p < NP; p++) begin
        if (wb_valid[p]) begin
          foreach (mq[i]) begin
            if (mq[i].id == wb_id[p]) begin
              e = mq[i];
              e.result = wdata[p];
              e.done = 1'b1;
              if (ex[p].valid) e.ex = ex[p];
              mq[i] = e;
            end
          end
        end
      end
      if (fire_commit) void'(mq.pop_front());
      if (fire_issue) begin
        e.id = 2'(m_tail);
        e.rd = dec_instr.rd;
        e.pc = dec_instr.pc;
        e.result = '0;
        e.done = 1'b0;
        e.ex = dec_instr.ex;
        e.ex.valid = 1'b0;
        mq.push_back(e);
        m_tail = (m_tail + 1) % NE;
      end
    end
  endtask

  function automatic logic [31:0] exp_clobber();
    logic [31:0] c = '0;
    foreach (mq[i]) if (!mq[i].done && mq[i].rd != 5'd0) c[mq[i].rd] = 1'b1;
    return c;
  endfunction

  // {valid, data} for an operand read: youngest producer of rs decides.
  function automatic logic [64:0] exp_fwd(input logic [4:0] rs);
    if (rs != 5'd0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].rd == rs) return mq[i].done ? {1'b1, mq[i].result} : 65'd0;
      end
    end
    return 65'd0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0; dec_valid = 1'b0; issue_ack = 1'b0; commit_ack = 1'b0;
    dec_instr = '0; rs1 = '0; rs2 = '0;
    wb_valid = '0; wb_id = '0; wdata = '0; ex = '0;
  endtask

  task automatic apply_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic issue_one(input logic [4:0] rd, input logic [63:0] pc);
    dec_valid = 1'b1;
    issue_ack = 1'b1;
    dec_instr = '0;
    dec_instr.pc = pc;
    dec_instr.rd = rd;
    dec_instr.op = 8'h33;
    dec_instr.valid = 1'b1;
    dec_instr.result = 64'hDEAD;
    dec_instr.trans_id = 2'd3;
    dec_instr.ex.valid = 1'b1;
  endtask

  task automatic issue_n(input int n);
    for (int k = 0; k < n; k++) begin
      issue_one(5'(k + 1), 64'h1000 + 64'(k * 4));
      tick();
    end
    idle();
  endtask

  task automatic set_wb(input int p, input logic [1:0] id, input logic [63:0] data);
    wb_valid[p] = 1'b1;
    wb_id[p] = id;
    wdata[p] = data;
    ex[p] = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle();
    rst = 1'b1; rs1 = 5'd1; rs2 = 5'd2; dec_valid = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
    n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_commit_valid got %b want 0", commit_valid); end
    n_checks++; if (rd_clobber !== 32'h0) begin n_fail++; $display("FAIL reset_clobber got %h want 0", rd_clobber); end
    n_checks++; if ({rs1_valid, rs1_data, rs2_valid, rs2_data} !== '0) begin
      n_fail++; $display("FAIL reset_fwd got %b/%h %b/%h want all 0", rs1_valid, rs1_data, rs2_valid, rs2_data); end
    n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL reset_issue_follow got %b want 1", issue_valid); end
    dec_valid = 1'b0;
    #1;
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset_issue_idle got %b want 0", issue_valid); end
  endtask

  task automatic test_fill();
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      issue_one(5'(k + 1), 64'h2000 + 64'(k));
      #1;
      n_checks++; if ({issue_valid, dec_ack, issue_instr.trans_id} !== {1'b1, 1'b1, 2'(k)}) begin
        n_fail++; $display("FAIL fill_issue_%0d got v=%b ack=%b id=%0d want 1 1 %0d", k, issue_valid, dec_ack, issue_instr.trans_id, k); end
      n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL fill_not_full_%0d got %b want 0", k, full); end
      tick();
    end
    issue_one(5'd9, 64'h2010);
    #1;
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full got %b want 1", full); end
    n_checks++; if ({issue_valid, dec_ack} !== 2'b00) begin n_fail++; $display("FAIL fill_blocked got %b%b want 00", issue_valid, dec_ack); end
    n_checks++; if (rd_clobber !== 32'h1E) begin n_fail++; $display("FAIL fill_clobber got %h want 1e", rd_clobber); end
    idle();
  endtask

  task automatic test_out_of_order();
    apply_reset();
    issue_n(4);
    set_wb(0, 2'd2, 64'hAA);
    #1;
    n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL ooo_wb2_now got %b want 0", commit_valid); end
    tick(); idle(); #1;
    n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL ooo_wait_id0 got %b want 0", commit_valid); end
    set_wb(1, 2'd0, 64'hBB);
    #1;
    n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL ooo_no_bypass got %b want 0", commit_valid); end
    tick(); idle(); #1;
    n_checks++; if ({commit_valid, commit_instr.trans_id, commit_instr.result} !== {1'b1, 2'd0, 64'hBB}) begin
      n_fail++; $display("FAIL ooo_commit0 got v=%b id=%0d r=%h want 1 0 bb", commit_valid, commit_instr.trans_id, commit_instr.result); end
    commit_ack = 1'b1;
    tick(); idle(); #1;
    n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL ooo_wait_id1 got %b want 0", commit_valid); end
    n_checks++; if (rd_clobber !== 32'h14) begin n_fail++; $display("FAIL ooo_clobber got %h want 14", rd_clobber); end
    commit_ack = 1'b1;
    tick(); idle();
    set_wb(0, 2'd1, 64'hCC);
    tick(); idle(); #1;
    n_checks++; if ({commit_valid, commit_instr.trans_id, commit_instr.result} !== {1'b1, 2'd1, 64'hCC}) begin
      n_fail++; $display("FAIL ooo_commit1 got v=%b id=%0d r=%h want 1 1 cc", commit_valid, commit_instr.trans_id, commit_instr.result); end
    commit_ack = 1'b1;
    tick(); #1;
    n_checks++; if ({commit_valid, commit_instr.trans_id, commit_instr.result} !== {1'b1, 2'd2, 64'hAA}) begin
      n_fail++; $display("FAIL ooo_commit2 got v=%b id=%0d r=%h want 1 2 aa", commit_valid, commit_instr.trans_id, commit_instr.result); end
    tick(); idle(); #1;
    n_checks++; if ({commit_valid, rd_clobber} !== {1'b0, 32'h10}) begin
      n_fail++; $display("FAIL ooo_wait_id3 got v=%b clob=%h want 0 10", commit_valid, rd_clobber); end
    set_wb(1, 2'd3, 64'hDD);
    ex[1].valid = 1'b1; ex[1].cause = 64'd5; ex[1].tval = 64'h77;
    tick(); idle(); #1;
    n_checks++; if ({commit_valid, commit_instr.result, commit_instr.ex} !== {1'b1, 64'hDD, 64'd5, 64'h77, 1'b1}) begin
      n_fail++; $display("FAIL ooo_commit3_ex got v=%b r=%h cause=%h ev=%b want 1 dd 5 1", commit_valid, commit_instr.result, commit_instr.ex.cause, commit_instr.ex.valid); end
    commit_ack = 1'b1;
    tick(); idle();
    set_wb(0, 2'd0, 64'hEE);
    tick(); idle(); #1;
    n_checks++; if ({full, commit_valid, rd_clobber} !== {1'b0, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL ooo_empty got full=%b v=%b clob=%h want 0 0 0", full, commit_valid, rd_clobber); end
  endtask

  task automatic test_forwarding();
    apply_reset();
    issue_one(5'd5, 64'h3000); tick();
    issue_one(5'd5, 64'h3004); tick();
    issue_one(5'd0, 64'h3008); tick();
    idle();
    set_wb(0, 2'd0, 64'h11);
    tick(); idle();
    rs1 = 5'd5; rs2 = 5'd5;
    #1;
    n_checks++; if ({rs1_valid, rs2_valid} !== 2'b00) begin n_fail++; $display("FAIL fwd_young_pending got %b%b want 00", rs1_valid, rs2_valid); end
    n_checks++; if (rd_clobber !== 32'h20) begin n_fail++; $display("FAIL fwd_clobber got %h want 20", rd_clobber); end
    set_wb(1, 2'd1, 64'h22);
    tick(); idle();
    rs1 = 5'd5; rs2 = 5'd0;
    #1;
    n_checks++; if ({rs1_valid, rs1_data} !== {1'b1, 64'h22}) begin n_fail++; $display("FAIL fwd_young_done got %b/%h want 1/22", rs1_valid, rs1_data); end
    n_checks++; if ({rs2_valid, rs2_data} !== 65'd0) begin n_fail++; $display("FAIL fwd_x0 got %b/%h want 0/0", rs2_valid, rs2_data); end
    set_wb(0, 2'd2, 64'h33);
    set_wb(1, 2'd2, 64'h44);
    tick(); idle();
    rs1 = 5'd0; rs2 = 5'd9;
    #1;
    n_checks++; if ({rs1_valid, rs1_data, rs2_valid, rs2_data} !== '0) begin
      n_fail++; $display("FAIL fwd_x0_miss got %b/%h %b/%h want 0", rs1_valid, rs1_data, rs2_valid, rs2_data); end
    commit_ack = 1'b1;
    #1;
    n_checks++; if (commit_instr.result !== 64'h11) begin n_fail++; $display("FAIL fwd_ret0 got %h want 11", commit_instr.result); end
    tick(); #1;
    n_checks++; if (commit_instr.result !== 64'h22) begin n_fail++; $display("FAIL fwd_ret1 got %h want 22", commit_instr.result); end
    tick(); #1;
    n_checks++; if ({commit_valid, commit_instr.result} !== {1'b1, 64'h44}) begin
      n_fail++; $display("FAIL fwd_port_prio got %b/%h want 1/44", commit_valid, commit_instr.result); end
    tick(); idle();
  endtask

  task automatic test_full_commit();
    apply_reset();
    issue_n(4);
    set_wb(0, 2'd0, 64'h100);
    set_wb(1, 2'd1, 64'h101);
    tick(); idle();
    issue_one(5'd6, 64'h4000);
    commit_ack = 1'b1;
    #1;
    n_checks++; if ({full, issue_valid, commit_valid} !== 3'b101) begin
      n_fail++; $display("FAIL fullc_same_cycle got full=%b iv=%b cv=%b want 1 0 1", full, issue_valid, commit_valid); end
    tick(); #1;
    n_checks++; if ({full, issue_valid, issue_instr.trans_id, commit_valid} !== {1'b0, 1'b1, 2'd0, 1'b1}) begin
      n_fail++; $display("FAIL fullc_next got full=%b iv=%b id=%0d cv=%b want 0 1 0 1", full, issue_valid, issue_instr.trans_id, commit_valid); end
    tick();
    commit_ack = 1'b0;
    issue_one(5'd7, 64'h4004);
    #1;
    n_checks++; if ({full, issue_valid, issue_instr.trans_id} !== {1'b0, 1'b1, 2'd1}) begin
      n_fail++; $display("FAIL fullc_count_held got full=%b iv=%b id=%0d want 0 1 1", full, issue_valid, issue_instr.trans_id); end
    tick(); idle(); #1;
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fullc_refull got %b want 1", full); end
  endtask

  task automatic test_wrap();
    logic [63:0] res [10];
    apply_reset();
    for (int t = 0; t < 12; t++) begin
      idle();
      if (t < 10) begin
        res[t] = {$urandom, $urandom};
        issue_one(5'(t % 7 + 1), 64'h5000 + 64'(t));
        exp_q.push_back(res[t]);
      end
      if (t >= 1 && t <= 10) set_wb(t % 2, 2'((t - 1) % 4), res[t - 1]);
      if (t >= 2) commit_ack = 1'b1;
      #1;
      if (t < 10) begin
        n_checks++; if ({issue_valid, issue_instr.trans_id} !== {1'b1, 2'(t % 4)}) begin
          n_fail++; $display("FAIL wrap_issue_%0d got v=%b id=%0d want 1 %0d", t, issue_valid, issue_instr.trans_id, t % 4); end
      end
      if (t >= 2 && exp_q.size() > 0) begin
        n_checks++; if ({commit_valid, commit_instr.trans_id, commit_instr.result} !== {1'b1, 2'((t - 2) % 4), exp_q[0]}) begin
          n_fail++; $display("FAIL wrap_commit_%0d got v=%b id=%0d r=%h want 1 %0d %h", t, commit_valid, commit_instr.trans_id, commit_instr.result, (t - 2) % 4, exp_q[0]); end
        void'(exp_q.pop_front());
      end
      tick();
    end
    idle();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_drain got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_flush();
    apply_reset();
    issue_n(3);
    flush = 1'b1;
    set_wb(0, 2'd0, 64'h55);
    issue_one(5'd7, 64'h6000);
    #1;
    n_checks++; if ({issue_valid, dec_ack} !== 2'b00) begin n_fail++; $display("FAIL flush_blocks_issue got %b%b want 00", issue_valid, dec_ack); end
    tick(); idle();
    rs1 = 5'd1;
    #1;
    n_checks++; if ({full, commit_valid, rd_clobber} !== {1'b0, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL flush_cleared got full=%b v=%b clob=%h want 0 0 0", full, commit_valid, rd_clobber); end
    n_checks++; if ({rs1_valid, rs1_data} !== 65'd0) begin n_fail++; $display("FAIL flush_wb_dropped got %b/%h want 0/0", rs1_valid, rs1_data); end
    for (int k = 0; k < 4; k++) begin
      issue_one(5'(k + 10), 64'h6100 + 64'(k));
      #1;
      n_checks++; if ({full, issue_instr.trans_id} !== {1'b0, 2'(k)}) begin
        n_fail++; $display("FAIL flush_refill_%0d got full=%b id=%0d want 0 %0d", k, full, issue_instr.trans_id, k); end
      tick();
    end
    idle(); #1;
    n_checks++; if ({full, commit_valid} !== 2'b10) begin n_fail++; $display("FAIL flush_refull got %b%b want 10", full, commit_valid); end
  endtask

  task automatic test_random();
    logic            exp_iv;
    scoreboard_entry exp_issue;
    apply_reset();
    for (int c = 0; c < 500; c++) begin
      idle();
      flush      = ($urandom_range(0, 39) == 0);
      dec_valid  = ($urandom_range(0, 3) != 0);
      issue_ack  = ($urandom_range(0, 3) != 0);
      commit_ack = ($urandom_range(0, 2) != 0);
      dec_instr.pc       = {$urandom, $urandom};
      dec_instr.rd       = 5'($urandom_range(0, 7));
      dec_instr.rs1      = 5'($urandom_range(0, 31));
      dec_instr.op       = 8'($urandom);
      dec_instr.trans_id = 2'($urandom);
      dec_instr.result   = {$urandom, $urandom};
      dec_instr.valid    = 1'($urandom);
      dec_instr.ex.cause = 64'($urandom);
      dec_instr.ex.valid = 1'($urandom);
      for (int p = 0; p < NP; p++) begin
        wb_valid[p]  = 1'($urandom);
        wb_id[p]     = 2'($urandom);
        wdata[p]     = {$urandom, $urandom};
        ex[p].valid  = ($urandom_range(0, 7) == 0);
        ex[p].cause  = 64'($urandom_range(0, 15));
        ex[p].tval   = {$urandom, $urandom};
      end
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      #1;
      exp_iv = dec_valid && (mq.size() < NE) && !flush;
      n_checks++; if ({issue_valid, dec_ack, full} !== {exp_iv, exp_iv && issue_ack, mq.size() == NE}) begin
        n_fail++; $display("FAIL rnd_handshake c=%0d got %b%b%b want %b%b%b", c, issue_valid, dec_ack, full, exp_iv, exp_iv && issue_ack, mq.size() == NE); end
      exp_issue = dec_instr;
      exp_issue.trans_id = 2'(m_tail);
      n_checks++; if (issue_instr !== exp_issue) begin
        n_fail++; $display("FAIL rnd_issue_instr c=%0d got id=%0d pc=%h want id=%0d pc=%h", c, issue_instr.trans_id, issue_instr.pc, m_tail, dec_instr.pc); end
      n_checks++; if (commit_valid !== (mq.size() > 0 && mq[0].done)) begin
        n_fail++; $display("FAIL rnd_commit_valid c=%0d got %b want %b", c, commit_valid, mq.size() > 0 && mq[0].done); end
      if (mq.size() > 0 && mq[0].done) begin
        n_checks++; if ({commit_instr.trans_id, commit_instr.pc, commit_instr.result, commit_instr.ex} !== {mq[0].id, mq[0].pc, mq[0].result, mq[0].ex}) begin
          n_fail++; $display("FAIL rnd_commit_instr c=%0d got id=%0d r=%h ev=%b want id=%0d r=%h ev=%b", c, commit_instr.trans_id, commit_instr.result, commit_instr.ex.valid, mq[0].id, mq[0].result, mq[0].ex.valid); end
      end
      n_checks++; if (rd_clobber !== exp_clobber()) begin
        n_fail++; $display("FAIL rnd_clobber c=%0d got %h want %h", c, rd_clobber, exp_clobber()); end
      n_checks++; if ({rs1_valid, rs1_data} !== exp_fwd(rs1)) begin
        n_fail++; $display("FAIL rnd_rs1 c=%0d rs=%0d got %b/%h want %h", c, rs1, rs1_valid, rs1_data, exp_fwd(rs1)); end
      n_checks++; if ({rs2_valid, rs2_data} !== exp_fwd(rs2)) begin
        n_fail++; $display("FAIL rnd_rs2 c=%0d rs=%0d got %b/%h want %h", c, rs2, rs2_valid, rs2_data, exp_fwd(rs2)); end
      tick();
    end
    idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    idle();
    test_reset();
    test_fill();
    test_out_of_order();
    test_forwarding();
    test_full_commit();
    test_wrap();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
